filter_loader: RTL and testbench
================================

# filter_loader

Memory-side writer for filter coefficients: accepts a valid/ready stream of 18-bit filter words and writes them into consecutive locations of the shared filter `Memory` write port A. It fills the region that `IssueFilter` later reads, starting at a programmed base address for a programmed word count. Completion is signalled with a one-cycle `done` pulse, and a running checksum is produced for host cross-checking.

## Interface
- `ADDR_WIDTH`, default 16: memory address width.
- `DATA_WIDTH`, default 18: filter word width.
- `LEN_WIDTH`, default 13: width of the word-count input and counter.
- `SUM_WIDTH`, default 24: checksum width.

Ports (name, direction, width, meaning):
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  begin a load; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first write address; captured on accepted `start`.
- `length`  in  LEN_WIDTH  number of words to write; captured on accepted `start`.
- `load_block`  in  1  stall request; holds `in_ready` low while high.
- `in_data`  in  DATA_WIDTH  stream word.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block can accept a word this cycle.
- `write_addr_a`  out  ADDR_WIDTH  memory write address.
- `write_data_a`  out  DATA_WIDTH  memory write data.
- `write_en_a`  out  1  memory write strobe.
- `busy`  out  1  high in any state except IDLE.
- `word_count`  out  LEN_WIDTH  words accepted in the current/last load.
- `checksum`  out  SUM_WIDTH  sum of accepted words, modulo 2^SUM_WIDTH.
- `done`  out  1  one-cycle pulse after the final write.

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE:
  - On `start`=1, capture `base_addr` and `length`, and clear `word_count` and `checksum`.
  - If `length`≠0, go to LOAD; if `length`=0, go directly to DONE with no writes.
- LOAD:
  - `in_ready` = !`load_block` (combinational).
  - A handshake occurs when `in_valid` && `in_ready`. On a handshake:
    - register `write_addr_a` = captured base + `word_count` (modulo 2^ADDR_WIDTH), `write_data_a` = `in_data`, `write_en_a`=1;
    - increment `word_count`;
    - add the zero-extended `in_data` to `checksum`.
  - No handshake: `write_en_a`=0 next cycle; addr/data hold their last values.
  - Handshake on the word where `word_count`+1 = length: go to DRAIN.
- DRAIN: `in_ready`=0; the final write is on the bus this cycle; go to DONE.
- DONE: `done`=1, `in_ready`=0, `write_en_a`=0; go to IDLE.
- `start` outside IDLE is ignored. `base_addr` and `length` changes after capture are ignored.
- Address wrap: base 16'hFFFF with length 3 writes FFFF, 0000, 0001.
- `word_count` and `checksum` hold their values in IDLE until the next accepted `start`.
- Reset (`rst`=0, any time, including mid-load): the state machine goes to IDLE and all outputs go to 0 immediately, without waiting for a clock edge. A partially written region is left as-is.

## Timing
- Reset values: `in_ready`=0, `write_en_a`=0, `write_addr_a`=0, `write_data_a`=0, `busy`=0, `word_count`=0, `checksum`=0, `done`=0.
- `start` at edge S → `busy`=1 and `in_ready` possible from cycle S+1.
- Latency from handshake at edge N to memory write: `write_en_a` is high during cycle N..N+1, and the memory commits at edge N+1.
- Last handshake at edge L: `done` is high during cycle L+1..L+2, and `busy` drops after edge L+2.
- Full throughput: one word per cycle with no bubbles when `in_valid`=1 and `load_block`=0.
- `load_block` affects `in_ready` in the same cycle. A write already registered still completes.
- `length`=0: `done` is high in the cycle after `start` is sampled, with no `write_en_a` pulse.
- `word_count` is LEN_WIDTH bits, so the maximum load is 2^LEN_WIDTH−1 words.

## Test plan
- Basic load: base=0x0100, length=4, words 1,2,3,4 streamed back-to-back → writes (0x0100,1) through (0x0103,4) on 4 consecutive cycles; `done` 2 cycles after the 4th handshake; `checksum`=10; `word_count`=4.
- Stall: length=255, incrementing data, `load_block` high from cycle 16 for 5 cycles → `in_ready`=0 during the stall and no writes one cycle later; all 255 words land at base..base+254; the `IssueFilter` readback matches.
- Valid gaps: `in_valid` toggling every cycle, length=8 → exactly 8 write pulses at consecutive addresses; `done` once.
- Wrap and zero length: base=0xFFFF, length=3 → addresses FFFF, 0000, 0001. length=0 → `done` high the cycle after `start` with no write.
- Checksum overflow: 300 words of 0x3FFFF → `checksum`=(300·0x3FFFF) mod 2^24.
- Reset mid-load: `rst` low after 5 of 10 handshakes → all outputs 0 immediately, no further writes. A new `start` after release restarts with `word_count`=0.

Source files
------------

// File: rtl/filter_loader.sv
// -----------------------------------------------------------------------------
// filter_loader
//
// Memory-side writer for filter coefficients. Accepts a valid/ready stream of
// filter words and writes them into consecutive locations of the shared
// filter Memory through write port A. The region starts at a programmed base
// address and spans a programmed word count. That region is the one the
// IssueFilter block later reads back. A one-cycle done pulse marks
// completion. A running checksum of the accepted words lets the host
// cross-check what was loaded.
//
// Parameters:
//   ADDR_WIDTH  memory address width
//   DATA_WIDTH  filter word width
//   LEN_WIDTH   width of the word-count input and internal counter
//   SUM_WIDTH   checksum width (sum is modulo 2^SUM_WIDTH)
//
// Ports:
//   clk           single clock, rising edge
//   rst           asynchronous, active-low reset
//   start         begin a load (only looked at while idle)
//   base_addr     first write address, captured with an accepted start
//   length        number of words to write, captured with an accepted start
//   load_block    stall request, forces in_ready low while high
//   in_data       stream word
//   in_valid      stream word valid
//   in_ready      block accepts a word this cycle
//   write_addr_a  memory write address (registered)
//   write_data_a  memory write data (registered)
//   write_en_a    memory write strobe (registered)
//   busy          high whenever a load is in progress
//   word_count    words accepted in the current or last load
//   checksum      sum of accepted words
//   done          one-cycle pulse after the final write
// -----------------------------------------------------------------------------
module filter_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 18,
  parameter int LEN_WIDTH  = 13,
  parameter int SUM_WIDTH  = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  input  logic                  load_block,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [ADDR_WIDTH-1:0] write_addr_a,
  output logic [DATA_WIDTH-1:0] write_data_a,
  output logic                  write_en_a,
  output logic                  busy,
  output logic [LEN_WIDTH-1:0]  word_count,
  output logic [SUM_WIDTH-1:0]  checksum,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Load parameters frozen at start so later changes on the inputs are ignored.
  logic [ADDR_WIDTH-1:0] base_q;
  logic [LEN_WIDTH-1:0]  length_q;

  logic                  start_ok;
  logic                  handshake;
  logic [LEN_WIDTH:0]    count_plus_one;
  logic                  last_word;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [SUM_WIDTH-1:0]  next_sum;

  assign start_ok  = (state == IDLE) && start;
  assign handshake = in_valid && in_ready;

  // One extra bit keeps the compare exact even for the maximum length.
  assign count_plus_one = {1'b0, word_count} + {{LEN_WIDTH{1'b0}}, 1'b1};
  assign last_word      = handshake && (count_plus_one == {1'b0, length_q});

  // The address counter is the base plus the words already accepted.
  // It wraps naturally at the top of the address space.
  assign next_addr = base_q + ADDR_WIDTH'(word_count);
  assign next_sum  = checksum + SUM_WIDTH'(in_data);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. A zero-length request skips straight to DONE.
  // DRAIN gives the last registered write its cycle on the bus before done.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          next_state = (length == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (last_word) begin
          next_state = DRAIN;
        end
      end
      DRAIN: begin
        next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // State-decoded outputs. These are combinational from the state register.
  // They therefore fall with the asynchronous reset without waiting for a clock.
  // load_block gates in_ready within the same cycle.
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = !load_block;
      end
      DRAIN: begin
        busy = 1'b1;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  // Captured load parameters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base_q   <= '0;
      length_q <= '0;
    end else if (start_ok) begin
      base_q   <= base_addr;
      length_q <= length;
    end
  end

  // Progress counters. They are cleared by an accepted start and advance on
  // every handshake. They hold while idle so the host can read the result
  // of the last load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_count <= '0;
      checksum   <= '0;
    end else if (start_ok) begin
      word_count <= '0;
      checksum   <= '0;
    end else if (handshake) begin
      word_count <= count_plus_one[LEN_WIDTH-1:0];
      checksum   <= next_sum;
    end
  end

  // Memory write port. Each accepted word becomes one registered write in the
  // following cycle. Without a handshake the strobe drops, while address and
  // data keep their last values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      write_en_a   <= 1'b0;
      write_addr_a <= '0;
      write_data_a <= '0;
    end else begin
      write_en_a <= handshake;
      if (handshake) begin
        write_addr_a <= next_addr;
        write_data_a <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_filter_loader.sv
// -----------------------------------------------------------------------------
// tb_filter_loader
//
// Self-checking bench for filter_loader. The bench decides cycle by cycle
// which words are accepted from what it drives. It tracks the expected
// writes, count and checksum with plain arithmetic. It also mirrors the
// memory through the write port to read regions back.
// -----------------------------------------------------------------------------
module tb_filter_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] base_addr;
  logic [12:0] length;
  logic        load_block;
  logic [17:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] write_addr_a;
  logic [17:0] write_data_a;
  logic        write_en_a;
  logic        busy;
  logic [12:0] word_count;
  logic [23:0] checksum;
  logic        done;

  int total;
  int bad;

  logic [17:0] mem [logic [15:0]];

  filter_loader dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .load_block   (load_block),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .write_addr_a (write_addr_a),
    .write_data_a (write_data_a),
    .write_en_a   (write_en_a),
    .busy         (busy),
    .word_count   (word_count),
    .checksum     (checksum),
    .done         (done)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stand-in for the filter Memory, written through port A
  always @(posedge clk) begin
    if (rst && write_en_a) begin
      mem[write_addr_a] = write_data_a;
    end
  end

  // Hard stop in case anything hangs
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd0);
    checkOutput({tag, "_en"},    32'(write_en_a), 32'd0);
    checkOutput({tag, "_addr"},  32'(write_addr_a), 32'd0);
    checkOutput({tag, "_data"},  32'(write_data_a), 32'd0);
    checkOutput({tag, "_busy"},  32'(busy), 32'd0);
    checkOutput({tag, "_count"}, 32'(word_count), 32'd0);
    checkOutput({tag, "_sum"},   32'(checksum), 32'd0);
    checkOutput({tag, "_done"},  32'(done), 32'd0);
  endtask

  // One full load. vmode: 0 valid always, 1 valid every other cycle,
  // 2 random valid/stall/start noise. dmode: 0 incrementing from 1,
  // 1 random, 2 all ones. A stall window is given by block_at/block_len.
  task automatic applyStimulus(input logic [15:0] base, input int len, input int vmode,
                               input int dmode, input int block_at, input int block_len);
    int          acc;
    int          cyc;
    int          pulses;
    int          limit;
    logic        prev_hs;
    logic        hs;
    logic [15:0] prev_addr;
    logic [17:0] prev_data;
    logic [23:0] sum;

    acc = 0; cyc = 0; pulses = 0; prev_hs = 1'b0; sum = '0;
    prev_addr = '0; prev_data = '0;
    limit = len * 8 + 64;

    @(posedge clk); #1;
    start = 1'b1; base_addr = base; length = 13'(len);
    in_valid = 1'b0; load_block = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 16'($urandom);
    length = 13'($urandom);

    if (len == 0) begin
      @(negedge clk);
      checkOutput("zl_done", 32'(done), 32'd1);
      checkOutput("zl_busy", 32'(busy), 32'd1);
      checkOutput("zl_en", 32'(write_en_a), 32'd0);
      checkOutput("zl_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("zl_done_end", 32'(done), 32'd0);
      checkOutput("zl_busy_end", 32'(busy), 32'd0);
      checkOutput("zl_en_end", 32'(write_en_a), 32'd0);
      checkOutput("zl_count", 32'(word_count), 32'd0);
      checkOutput("zl_sum", 32'(checksum), 32'd0);
      return;
    end

    while (acc < len && cyc < limit) begin
      case (vmode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc % 2 == 0);
        default: in_valid = ($urandom % 4) != 0;
      endcase
      load_block = (cyc >= block_at && cyc < block_at + block_len);
      if (vmode == 2) begin
        if ($urandom % 5 == 0) load_block = 1'b1;
        start = 1'($urandom);
      end
      case (dmode)
        0:       in_data = 18'(acc + 1);
        1:       in_data = 18'($urandom);
        default: in_data = 18'h3FFFF;
      endcase

      @(negedge clk);
      checkOutput("ready", 32'(in_ready), 32'(!load_block));
      checkOutput("busy", 32'(busy), 32'd1);
      checkOutput("done_low", 32'(done), 32'd0);
      checkOutput("wr_en", 32'(write_en_a), 32'(prev_hs));
      checkOutput("count", 32'(word_count), 32'(acc));
      checkOutput("sum_run", 32'(checksum), 32'(sum));
      if (prev_hs) begin
        checkOutput("wr_addr", 32'(write_addr_a), 32'(prev_addr));
        checkOutput("wr_data", 32'(write_data_a), 32'(prev_data));
      end
      if (write_en_a) pulses++;

      hs = in_valid && !load_block;
      if (hs) begin
        prev_addr = base + 16'(acc);
        prev_data = in_data;
        sum       = sum + 24'(in_data);
        acc++;
      end
      prev_hs = hs;
      @(posedge clk); #1;
      cyc++;
    end

    if (acc < len) begin
      checkOutput("timeout", 32'(acc), 32'(len));
      return;
    end

    // Final write on the bus. Extra offered words must not be taken.
    start = 1'b0; in_valid = 1'b1; load_block = 1'b0; in_data = 18'h15555;
    @(negedge clk);
    checkOutput("last_en", 32'(write_en_a), 32'd1);
    checkOutput("last_addr", 32'(write_addr_a), 32'(prev_addr));
    checkOutput("last_data", 32'(write_data_a), 32'(prev_data));
    checkOutput("drain_ready", 32'(in_ready), 32'd0);
    checkOutput("drain_done", 32'(done), 32'd0);
    if (write_en_a) pulses++;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_en", 32'(write_en_a), 32'd0);
    checkOutput("done_ready", 32'(in_ready), 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("done_end", 32'(done), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_en", 32'(write_en_a), 32'd0);
    checkOutput("final_count", 32'(word_count), 32'(len));
    checkOutput("final_sum", 32'(checksum), 32'(sum));
    checkOutput("pulses", 32'(pulses), 32'(len));
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("hold_count", 32'(word_count), 32'(len));
    checkOutput("hold_sum", 32'(checksum), 32'(sum));
    checkOutput("hold_done", 32'(done), 32'd0);
  endtask

  // Interrupt a 10-word load after 5 handshakes with an asynchronous reset.
  task automatic reset_mid_load();
    int acc;
    acc = 0;
    @(posedge clk); #1;
    start = 1'b1; base_addr = 16'h4000; length = 13'd10;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; load_block = 1'b0;
    while (acc < 5) begin
      in_data = 18'(acc + 7);
      @(posedge clk); #1;
      acc++;
    end
    checkOutput("pre_rst_en", 32'(write_en_a), 32'd1);
    checkOutput("pre_rst_count", 32'(word_count), 32'd5);
    #1;
    rst = 1'b0;
    #1;
    check_all_zero("midrst");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_hold_en", 32'(write_en_a), 32'd0);
      checkOutput("rst_hold_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    for (int i = 5; i < 10; i++) begin
      checkOutput("no_late_write", 32'(mem.exists(16'(16'h4000 + i))), 32'd0);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b0; start = 1'b0; base_addr = '0; length = '0;
    load_block = 1'b0; in_data = '0; in_valid = 1'b0;

    #12;
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b1;

    $display("[TB] basic load");
    applyStimulus(16'h0100, 4, 0, 0, 1000, 0);
    checkOutput("basic_sum", 32'(checksum), 32'd10);

    $display("[TB] stall load");
    applyStimulus(16'h2000, 255, 0, 0, 16, 5);
    for (int i = 0; i < 255; i++) begin
      checkOutput("readback", 32'(mem[16'(16'h2000 + i)]), 32'(i + 1));
    end

    $display("[TB] valid gaps");
    applyStimulus(16'h0300, 8, 1, 1, 1000, 0);

    $display("[TB] address wrap");
    applyStimulus(16'hFFFF, 3, 0, 0, 1000, 0);
    checkOutput("wrap_ffff", 32'(mem[16'hFFFF]), 32'd1);
    checkOutput("wrap_0000", 32'(mem[16'h0000]), 32'd2);
    checkOutput("wrap_0001", 32'(mem[16'h0001]), 32'd3);

    $display("[TB] zero length");
    applyStimulus(16'h0500, 0, 0, 0, 1000, 0);

    $display("[TB] checksum overflow");
    applyStimulus(16'h6000, 300, 0, 2, 1000, 0);
    checkOutput("ovf_sum", 32'(checksum), 32'd11534036);

    $display("[TB] random loads");
    for (int n = 0; n < 6; n++) begin
      applyStimulus(16'($urandom), int'($urandom_range(1, 40)), 2, 1,
                    int'($urandom_range(0, 20)), int'($urandom_range(0, 6)));
    end

    $display("[TB] reset mid-load");
    reset_mid_load();
    applyStimulus(16'h4000, 10, 0, 1, 1000, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
